// File: rtl/dff_stim_seq_pkg.sv
// Shared state encoding and elaboration-time helpers for the DFF stimulus sequencer.
package dff_stim_seq_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRstp  = 3'd1,
        StShift = 3'd2,
        StHold  = 3'd3,
        StDone  = 3'd4
    } state_e;

    // Bits needed to hold values 0..v-1; bounded loop keeps it a plain constant function.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dff_stim_seq_slot_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero (last cycle of a span).
module dff_stim_seq_slot_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rstin,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstin) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == '0);

endmodule

// File: rtl/dff_stim_seq.sv
// Stimulus sequencer for the GAL DFF test block: reset pulse, LSB-first pattern with
// slotted ce strobes, hold window and a done pulse. All outputs are registered.
module dff_stim_seq
    import dff_stim_seq_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CE_DIV      = 2,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rstin,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_pattern,
    output logic             o_d,
    output logic             o_ce,
    output logic             o_rst_out,
    output logic             o_oe,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CNT_W    = clog2(max3(CE_DIV, RST_CYCLES, HOLD_CYCLES) + 1);
    localparam int unsigned BIT_W    = clog2(WIDTH + 1);
    localparam bit          HAS_HOLD = (HOLD_CYCLES > 0);

    // Timer load values are span length minus one: o_tc marks the final cycle.
    localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_SLOT = CNT_W'(CE_DIV - 1);
    localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(HAS_HOLD ? HOLD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [BIT_W-1:0]   r_bit;
    logic               w_last_bit;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_tc;
    logic               w_ce_nxt;

    logic r_d;
    logic r_ce;
    logic r_rst_out;
    logic r_oe;
    logic r_busy;
    logic r_done;

    dff_stim_seq_slot_timer #(
        .CNT_W (CNT_W)
    ) u_slot_timer (
        .i_clk      (i_clk),
        .i_rstin    (i_rstin),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    assign w_last_bit  = (r_bit == LAST_BIT);
    assign w_shift_nxt = r_shift >> 1;

    // Next state and timer reload; every state entry reloads, which also clears stale counts.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StRstp;
                    w_load      = 1'b1;
                    w_load_val  = LD_RST;
                end
            end
            StRstp: begin
                if (w_tc) begin
                    w_state_nxt = StShift;
                    w_load      = 1'b1;
                    w_load_val  = LD_SLOT;
                end
            end
            StShift: begin
                if (w_tc) begin
                    w_load = 1'b1;
                    if (!w_last_bit) begin
                        w_load_val = LD_SLOT;
                    end else if (HAS_HOLD) begin
                        w_state_nxt = StHold;
                        w_load_val  = LD_HOLD;
                    end else begin
                        w_state_nxt = StDone;
                    end
                end
            end
            StHold: begin
                if (w_tc) begin
                    w_state_nxt = StDone;
                    w_load      = 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_load      = 1'b1;
            end
            default: begin
                w_state_nxt = StIdle;
                w_load      = 1'b1;
            end
        endcase
    end

    // ce is registered, so predict whether the coming cycle is the last of its slot.
    assign w_ce_nxt = (w_state_nxt == StShift) &&
                      (w_load ? (w_load_val == '0) : (w_cnt == CNT_ONE));

    always_ff @(posedge i_clk) begin
        if (!i_rstin) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit     <= '0;
            r_d       <= 1'b0;
            r_ce      <= 1'b0;
            r_rst_out <= 1'b0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ce    <= w_ce_nxt;
            unique case (r_state)
                StIdle: begin
                    r_bit  <= '0;
                    r_d    <= 1'b0;
                    r_oe   <= 1'b0;
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_shift   <= i_pattern;
                        r_rst_out <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_rst_out <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                StRstp: begin
                    if (w_tc) begin
                        r_rst_out <= 1'b0;
                        r_oe      <= 1'b1;
                        r_d       <= r_shift[0];
                        r_bit     <= '0;
                    end
                end
                StShift: begin
                    if (w_tc) begin
                        if (!w_last_bit) begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= w_shift_nxt;
                            r_d     <= w_shift_nxt[0];
                        end else begin
                            // d keeps the final pattern bit through HOLD.
                            r_bit  <= '0;
                            r_done <= !HAS_HOLD;
                        end
                    end
                end
                StHold: begin
                    if (w_tc) begin
                        r_done <= 1'b1;
                    end
                end
                StDone: begin
                    r_bit     <= '0;
                    r_d       <= 1'b0;
                    r_rst_out <= 1'b0;
                    r_oe      <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
                default: begin
                    r_bit     <= '0;
                    r_d       <= 1'b0;
                    r_rst_out <= 1'b0;
                    r_oe      <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign o_d       = r_d;
    assign o_ce      = r_ce;
    assign o_rst_out = r_rst_out;
    assign o_oe      = r_oe;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_dff_stim_seq.sv
// Bench for dff_stim_seq: default instance plus a CE_DIV=1/HOLD_CYCLES=0 instance, both
// checked every cycle against a run-time-indexed model of the stimulus sequence.
module tb_dff_stim_seq;

    localparam int W     = 4;
    localparam int RA    = 2;
    localparam int CA    = 2;
    localparam int HA    = 2;
    localparam int RB    = 2;
    localparam int CB    = 1;
    localparam int HB    = 0;
    localparam int RUN_A = RA + W * CA + HA + 1;
    localparam int RUN_B = RB + W * CB + HB + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstin   = 1'b0;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic [W-1:0] pat_a   = '0;
    logic [W-1:0] pat_b   = '0;

    logic d_a, ce_a, rst_a, oe_a, busy_a, done_a;
    logic d_b, ce_b, rst_b, oe_b, busy_b, done_b;
    logic [5:0] obs_a, obs_b;
    assign obs_a = {d_a, ce_a, rst_a, oe_a, busy_a, done_a};
    assign obs_b = {d_b, ce_b, rst_b, oe_b, busy_b, done_b};

    dff_stim_seq #(
        .WIDTH (W), .CE_DIV (CA), .RST_CYCLES (RA), .HOLD_CYCLES (HA)
    ) u_dut_a (
        .i_clk (clk), .i_rstin (rstin), .i_start (start_a), .i_pattern (pat_a),
        .o_d (d_a), .o_ce (ce_a), .o_rst_out (rst_a), .o_oe (oe_a),
        .o_busy (busy_a), .o_done (done_a)
    );

    dff_stim_seq #(
        .WIDTH (W), .CE_DIV (CB), .RST_CYCLES (RB), .HOLD_CYCLES (HB)
    ) u_dut_b (
        .i_clk (clk), .i_rstin (rstin), .i_start (start_b), .i_pattern (pat_b),
        .o_d (d_b), .o_ce (ce_b), .o_rst_out (rst_b), .o_oe (oe_b),
        .o_busy (busy_b), .o_done (done_b)
    );

    int checks   = 0;
    int failures = 0;

    // Model: tm_* = cycle number within the current run (0 = idle), pm_* = latched pattern.
    int         tm_a = 0;
    int         tm_b = 0;
    logic [7:0] pm_a = '0;
    logic [7:0] pm_b = '0;

    always @(posedge clk) begin
        if (!rstin) begin
            tm_a = 0;
            tm_b = 0;
        end else begin
            if (tm_a == 0) begin
                if (start_a) begin
                    tm_a = 1;
                    pm_a = {4'b0, pat_a};
                end
            end else if (tm_a == RUN_A) tm_a = 0;
            else tm_a++;
            if (tm_b == 0) begin
                if (start_b) begin
                    tm_b = 1;
                    pm_b = {4'b0, pat_b};
                end
            end else if (tm_b == RUN_B) tm_b = 0;
            else tm_b++;
        end
    end

    // Expected {d, ce, rst_out, oe, busy, done} at cycle t of a run.
    function automatic logic [5:0] exp_out(int r, int w, int c, int h, logic [7:0] p, int t);
        int u;
        if (t == 0) return 6'b000000;
        if (t <= r) return 6'b001010;
        if (t <= r + w * c) begin
            u = t - r - 1;
            return {p[u / c], ((u % c) == c - 1), 4'b0110};
        end
        if (t <= r + w * c + h) return {p[w - 1], 5'b00110};
        return 6'b000111;
    endfunction

    // d is unconstrained during the done cycle.
    function automatic logic [5:0] exp_mask(int r, int w, int c, int h, int t);
        return (t == r + w * c + h + 1) ? 6'b011111 : 6'b111111;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] ea, ma, eb, mb;

    task automatic test_reset();
        rstin   = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        pat_a   = 4'($urandom);
        pat_b   = 4'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_a !== 6'b0 || obs_b !== 6'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got_a=%b got_b=%b exp=000000",
                         i, obs_a, obs_b);
            end
        end
        rstin = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        checks++;
        if (rst_a !== 1'b1 || busy_a !== 1'b1 || rst_b !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_run got rst_a=%b busy_a=%b rst_b=%b exp 1 1 1",
                     rst_a, busy_a, rst_b);
        end
        for (int i = 0; i < RUN_A + 1; i++) begin
            step();
            ea = exp_out(RA, W, CA, HA, pm_a, tm_a);
            ma = exp_mask(RA, W, CA, HA, tm_a);
            eb = exp_out(RB, W, CB, HB, pm_b, tm_b);
            mb = exp_mask(RB, W, CB, HB, tm_b);
            checks++;
            if ((obs_a & ma) !== (ea & ma) || (obs_b & mb) !== (eb & mb)) begin
                failures++;
                $display("FAIL reset_run t=%0d got_a=%b exp_a=%b got_b=%b exp_b=%b",
                         tm_a, obs_a, ea, obs_b, eb);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] ce_m, done_m, rst_m, oe_m;
        logic [3:0]  cap;
        int          n;
        ce_m = '0; done_m = '0; rst_m = '0; oe_m = '0; cap = '0; n = 0;
        pat_a   = 4'b1011;
        start_a = 1'b1;
        for (int cyc = 1; cyc < 16; cyc++) begin
            step();
            start_a = 1'b0;
            ce_m[cyc] = ce_a; done_m[cyc] = done_a; rst_m[cyc] = rst_a; oe_m[cyc] = oe_a;
            if (ce_a && n < 4) begin
                cap[n] = d_a;
                n++;
            end
            ea = exp_out(RA, W, CA, HA, pm_a, tm_a);
            ma = exp_mask(RA, W, CA, HA, tm_a);
            checks++;
            if ((obs_a & ma) !== (ea & ma)) begin
                failures++;
                $display("FAIL basic_cycle cyc=%0d got=%b exp=%b", cyc, obs_a, ea);
            end
        end
        checks++;
        if (ce_m !== 16'h0550) begin
            failures++;
            $display("FAIL basic_ce_cycles got=%h exp=0550", ce_m);
        end
        checks++;
        if (done_m !== 16'h2000 || rst_m !== 16'h0006 || oe_m !== 16'h3ff8) begin
            failures++;
            $display("FAIL basic_ctrl got done=%h rst=%h oe=%h exp 2000 0006 3ff8",
                     done_m, rst_m, oe_m);
        end
        checks++;
        if (cap !== 4'b1011) begin
            failures++;
            $display("FAIL basic_capture got=%b exp=1011", cap);
        end
    endtask

    task automatic test_fast();
        logic [15:0] ce_m, done_m;
        logic [3:0]  cap;
        int          n;
        ce_m = '0; done_m = '0; cap = '0; n = 0;
        pat_b   = 4'b0110;
        start_b = 1'b1;
        for (int cyc = 1; cyc < 12; cyc++) begin
            step();
            start_b = 1'b0;
            ce_m[cyc] = ce_b;
            done_m[cyc] = done_b;
            if (ce_b && n < 4) begin
                cap[n] = d_b;
                n++;
            end
            eb = exp_out(RB, W, CB, HB, pm_b, tm_b);
            mb = exp_mask(RB, W, CB, HB, tm_b);
            checks++;
            if ((obs_b & mb) !== (eb & mb)) begin
                failures++;
                $display("FAIL fast_cycle cyc=%0d got=%b exp=%b", cyc, obs_b, eb);
            end
        end
        checks++;
        if (ce_m !== 16'h0078 || done_m !== 16'h0080) begin
            failures++;
            $display("FAIL fast_timing got ce=%h done=%h exp 0078 0080", ce_m, done_m);
        end
        checks++;
        if (cap !== 4'b0110) begin
            failures++;
            $display("FAIL fast_capture got=%b exp=0110", cap);
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] rst_m;
        logic [3:0]  cap;
        int          n;
        rst_m = '0; cap = '0; n = 0;
        pat_a   = 4'b1011;
        start_a = 1'b1;
        for (int cyc = 1; cyc < 16; cyc++) begin
            step();
            start_a = (cyc == 5);
            if (cyc == 5) pat_a = 4'b0000;
            rst_m[cyc] = rst_a;
            if (ce_a && n < 4) begin
                cap[n] = d_a;
                n++;
            end
            ea = exp_out(RA, W, CA, HA, pm_a, tm_a);
            ma = exp_mask(RA, W, CA, HA, tm_a);
            checks++;
            if ((obs_a & ma) !== (ea & ma)) begin
                failures++;
                $display("FAIL ignore_cycle cyc=%0d got=%b exp=%b", cyc, obs_a, ea);
            end
        end
        checks++;
        if (cap !== 4'b1011 || rst_m !== 16'h0006) begin
            failures++;
            $display("FAIL ignore_start got cap=%b rst=%h exp 1011 0006", cap, rst_m);
        end
    endtask

    task automatic test_abort();
        logic       seen_done;
        logic [3:0] p, cap;
        int         n;
        seen_done = 1'b0;
        p         = 4'($urandom);
        pat_a     = p;
        start_a   = 1'b1;
        for (int cyc = 1; cyc < 20; cyc++) begin
            step();
            start_a = 1'b0;
            if (cyc == 7) rstin = 1'b0;
            if (cyc == 8) begin
                rstin = 1'b1;
                checks++;
                if (obs_a !== 6'b0) begin
                    failures++;
                    $display("FAIL abort_clear got=%b exp=000000", obs_a);
                end
            end
            if (cyc > 7 && done_a) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=%b exp=0", seen_done);
        end
        p = 4'($urandom);
        pat_a = p; start_a = 1'b1; cap = '0; n = 0;
        for (int cyc = 1; cyc < RUN_A + 2; cyc++) begin
            step();
            start_a = 1'b0;
            if (ce_a && n < 4) begin
                cap[n] = d_a;
                n++;
            end
            ea = exp_out(RA, W, CA, HA, pm_a, tm_a);
            ma = exp_mask(RA, W, CA, HA, tm_a);
            checks++;
            if ((obs_a & ma) !== (ea & ma)) begin
                failures++;
                $display("FAIL abort_replay cyc=%0d got=%b exp=%b", cyc, obs_a, ea);
            end
        end
        checks++;
        if (cap !== p) begin
            failures++;
            $display("FAIL abort_replay_capture got=%b exp=%b", cap, p);
        end
    endtask

    task automatic test_back_to_back();
        logic prev1, prev2;
        int   dones;
        prev1 = 1'b0; prev2 = 1'b0; dones = 0;
        pat_a   = 4'($urandom);
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            ea = exp_out(RA, W, CA, HA, pm_a, tm_a);
            ma = exp_mask(RA, W, CA, HA, tm_a);
            checks++;
            if ((obs_a & ma) !== (ea & ma)) begin
                failures++;
                $display("FAIL b2b_cycle cyc=%0d got=%b exp=%b", cyc, obs_a, ea);
            end
            if (prev1) begin
                checks++;
                if (busy_a !== 1'b0 || oe_a !== 1'b0 || rst_a !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_gap cyc=%0d got busy=%b oe=%b rst=%b exp 0 0 0",
                             cyc, busy_a, oe_a, rst_a);
                end
            end
            if (prev2) begin
                checks++;
                if (rst_a !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_restart cyc=%0d got rst=%b exp=1", cyc, rst_a);
                end
            end
            if (done_a) dones++;
            prev2 = prev1;
            prev1 = done_a;
            pat_a = 4'($urandom);
        end
        start_a = 1'b0;
        checks++;
        if (dones != 2) begin
            failures++;
            $display("FAIL b2b_runs got=%0d exp=2", dones);
        end
        for (int i = 0; i < 20 && (tm_a != 0 || busy_a); i++) begin
            step();
            ea = exp_out(RA, W, CA, HA, pm_a, tm_a);
            ma = exp_mask(RA, W, CA, HA, tm_a);
            checks++;
            if ((obs_a & ma) !== (ea & ma)) begin
                failures++;
                $display("FAIL b2b_drain t=%0d got=%b exp=%b", tm_a, obs_a, ea);
            end
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got busy=%b exp=0", busy_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300 + RUN_A + 2; i++) begin
            if (i < 300) begin
                start_a = ($urandom_range(0, 3) == 0);
                start_b = ($urandom_range(0, 2) == 0);
                rstin   = ($urandom_range(0, 39) != 0);
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
                rstin   = 1'b1;
            end
            pat_a = 4'($urandom);
            pat_b = 4'($urandom);
            step();
            ea = exp_out(RA, W, CA, HA, pm_a, tm_a);
            ma = exp_mask(RA, W, CA, HA, tm_a);
            eb = exp_out(RB, W, CB, HB, pm_b, tm_b);
            mb = exp_mask(RB, W, CB, HB, tm_b);
            checks++;
            if ((obs_a & ma) !== (ea & ma) || (obs_b & mb) !== (eb & mb)) begin
                failures++;
                $display("FAIL random i=%0d got_a=%b exp_a=%b got_b=%b exp_b=%b",
                         i, obs_a, ea, obs_b, eb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fast();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dff_stim_seq.md
Name: dff_stim_seq

Overview:
Stimulus sequencer directly upstream of the GAL D-flip-flop test block. It drives that block's d, ce, rstin and oe pins.
On each start request it runs a fixed sequence: reset pulse, output enable, then a programmable bit pattern shifted out LSB-first with slotted clock-enable strobes, a hold window, and a done pulse.
It lets the bench or board exercise the DFF's reset-to-0/1 and ce-gated capture deterministically.

Parameters:
WIDTH, 4, number of pattern bits shifted onto d (1..8)
CE_DIV, 2, cycles per bit slot; ce strobes on last cycle of each slot (>=1)
RST_CYCLES, 2, cycles rst_out held high per run (>=1)
HOLD_CYCLES, 2, cycles after last slot with ce=0 before done (>=0)

Ports:
clk  input  1  single system clock; all logic on posedge clk
rstin  input  1  reset; synchronous, active-low
start  input  1  run request; sampled only in IDLE
pattern  input  WIDTH  bits to emit, latched on accepted start
d  output  1  data to DFF d pin
ce  output  1  clock-enable strobe to DFF ce pin
rst_out  output  1  active-high reset to DFF rstin pin
oe  output  1  output enable to DFF oe pin
busy  output  1  high from accepted start through DONE
done  output  1  one-cycle pulse in DONE state

Behaviour:
- All outputs registered. rstin low at a posedge: state=IDLE, all counters 0, shift reg 0.
- Reset values: d=0, ce=0, rst_out=0, oe=0, busy=0, done=0. Reset mid-run aborts immediately, with no done pulse.
- FSM states: IDLE, RSTP, SHIFT, HOLD, DONE.
- IDLE:
  - start=1 at edge k: latch pattern, go to RSTP.
  - From cycle k+1: rst_out=1, busy=1, oe=0.
- RSTP:
  - rst_out=1 for exactly RST_CYCLES cycles, then SHIFT.
  - rst_out=0 and oe=1 from the first SHIFT cycle.
- SHIFT:
  - WIDTH slots of CE_DIV cycles each.
  - d = pattern[i] for the whole of slot i (i=0 first).
  - ce=1 only on the final cycle of each slot.
  - CE_DIV=1: ce=1 every SHIFT cycle.
  - After slot WIDTH-1, go to HOLD, or to DONE if HOLD_CYCLES=0.
- HOLD:
  - ce=0; d holds pattern[WIDTH-1]; oe=1; lasts HOLD_CYCLES cycles.
- DONE:
  - Exactly 1 cycle: done=1, busy=1, oe=1, ce=0. Then IDLE.
  - In IDLE: oe=0, d=0, busy=0.
- Run length: RST_CYCLES + WIDTH*CE_DIV + HOLD_CYCLES + 1 cycles of busy.
- Restart gap: at least one IDLE cycle between runs.
- Start handling:
  - start outside IDLE is ignored, and pattern changes during a run are ignored.
  - start held high continuously: a new run begins on the edge after the IDLE cycle.
- Counters:
  - One slot/cycle counter, width clog2(max(CE_DIV,RST_CYCLES,HOLD_CYCLES)+1).
  - One bit index, width clog2(WIDTH+1).
  - No wrap inside a run; both counters clear on every state entry.
- rst_out never coincides with ce=1 or oe=1.

Decomposition:
- Shared include dff_stim_defs.vh: state encodings (IDLE=0, RSTP=1, SHIFT=2, HOLD=3, DONE=4, 3-bit) and the clog2 helper function.
- One sub-module, stim_slot_timer:
  - Loadable down-counter with terminal-count pulse.
  - Used for the RSTP, SHIFT-slot and HOLD durations.
- FSM and shift register stay in dff_stim_seq.

Test Plan:
1. Reset: rstin=0 for 3 cycles with start=1 -> all outputs 0, busy never rises; first run starts on the edge after rstin=1.
2. Defaults, pattern=4'b1011, start pulse at cycle 0:
   - rst_out=1 cycles 1-2; oe=1 from cycle 3.
   - d = 1,1,0,1 over slots of 2 cycles; ce=1 at cycles 4, 6, 8, 10.
   - HOLD at cycles 11-12; done=1 at cycle 13; idle at 14.
3. CE_DIV=1, HOLD_CYCLES=0, pattern=4'b0110 -> ce=1 on 4 consecutive cycles with d=0,1,1,0, then done on the next cycle.
4. start pulsed during SHIFT and pattern changed to 4'b0000 mid-run -> no restart; d stream unchanged from the latched 1011.
5. rstin=0 during the slot-2 cycle of SHIFT -> next cycle all outputs 0, no done pulse; a fresh start replays the full sequence.
6. start held high for 40 cycles -> back-to-back runs with exactly one IDLE cycle (oe=0, busy=0) between done and the next rst_out.
